// File: rtl/disp_pkg.sv
// ============================================================================
// Module      : disp_pkg
// Description : Shared constants, types and helpers for the display multiplexer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package disp_pkg;

    localparam int NUM_DIGITS = 6;

    typedef logic [2:0] digit_idx_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'h3F;

    // Active-low {g,f,e,d,c,b,a}; element 0 is the pattern for digit 0.
    localparam logic [9:0][6:0] SEG_DIGITS = {
        7'h10, 7'h00, 7'h78, 7'h02, 7'h12,
        7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

    // Largest legal value for the digit shown in a given scan slot.
    function automatic logic [3:0] digit_max(input digit_idx_t idx);
        case (idx)
            3'd1, 3'd3: return 4'd5;
            3'd5:       return 4'd2;
            default:    return 4'd9;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/disp_mux_if.sv
// ============================================================================
// Module      : disp_mux_if
// Description : Digit inputs, control strobes and display drive of disp_mux.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface disp_mux_if;

    logic [3:0] disp_seg_lsd;
    logic [2:0] disp_seg_msd;
    logic [3:0] disp_min_lsd;
    logic [2:0] disp_min_msd;
    logic [3:0] disp_hor_lsd;
    logic [1:0] disp_hor_msd;
    logic       disp_tick_1hz;
    logic       disp_lzb;
    logic       disp_blank;
    logic [5:0] disp_an;
    logic [6:0] disp_seg;
    logic       disp_dp;

    modport master (
        output disp_seg_lsd, disp_seg_msd, disp_min_lsd, disp_min_msd,
               disp_hor_lsd, disp_hor_msd, disp_tick_1hz, disp_lzb, disp_blank,
        input  disp_an, disp_seg, disp_dp
    );

    modport slave (
        input  disp_seg_lsd, disp_seg_msd, disp_min_lsd, disp_min_msd,
               disp_hor_lsd, disp_hor_msd, disp_tick_1hz, disp_lzb, disp_blank,
        output disp_an, disp_seg, disp_dp
    );

endinterface

`default_nettype wire

// File: rtl/disp_mux_bcd_7seg.sv
// ============================================================================
// Module      : bcd_7seg
// Description : BCD digit to active-low seven-segment pattern, dash if invalid.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_7seg
    import disp_pkg::*;
(
    input  wire logic [3:0] i_digit,
    input  wire logic [3:0] i_max,
    output logic      [6:0] o_seg
);

    // i_max never exceeds 9, so a passing digit always indexes the table.
    always_comb begin
        o_seg = SEG_DASH;
        if (i_digit <= i_max) begin
            o_seg = SEG_DIGITS[i_digit];
        end
    end

endmodule

`default_nettype wire

// File: rtl/disp_mux.sv
// ============================================================================
// Module      : disp_mux
// Description : Six-digit multiplexed seven-segment driver with frame snapshot.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module disp_mux
    import disp_pkg::*;
#(
    parameter int SCAN_DIV   = 50000,
    parameter int GAP_CYCLES = 500
) (
    input  wire logic disp_clock,
    input  wire logic disp_reset,
    disp_mux_if.slave bus
);

    localparam int               CNT_W      = $clog2(SCAN_DIV);
    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] c_cnt_gap  = CNT_W'(GAP_CYCLES);
    localparam digit_idx_t       c_idx_last = digit_idx_t'(NUM_DIGITS - 1);

    logic [CNT_W-1:0]               cnt_q, cnt_d;
    digit_idx_t                     idx_q, idx_d;
    logic                           colon_q, colon_d;
    logic [NUM_DIGITS-1:0][3:0]     snap_q, snap_d;
    logic [5:0]                     an_q, an_d;
    logic [6:0]                     seg_q, seg_d;
    logic                           dp_q, dp_d;

    logic [NUM_DIGITS-1:0][3:0]     w_digits;
    logic [3:0]                     w_digit;
    logic [3:0]                     w_max;
    logic [6:0]                     w_dec_seg;
    logic                           w_lit;
    logic                           w_lz_blank;

    // Slot order: element 0 is seconds units, element 5 is hours tens.
    assign w_digits = {
        2'b00, bus.disp_hor_msd, bus.disp_hor_lsd,
        1'b0,  bus.disp_min_msd, bus.disp_min_lsd,
        1'b0,  bus.disp_seg_msd, bus.disp_seg_lsd
    };

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge disp_clock) begin
        if (disp_reset) begin
            cnt_q   <= '0;
            idx_q   <= '0;
            colon_q <= 1'b0;
            snap_q  <= '0;
            an_q    <= 6'h3F;
            seg_q   <= SEG_BLANK;
            dp_q    <= 1'b1;
        end else begin
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            colon_q <= colon_d;
            snap_q  <= snap_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
            dp_q    <= dp_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic: slot counter, digit index, frame snapshot, colon
    // ------------------------------------------------------------------
    always_comb begin
        cnt_d   = cnt_q + CNT_W'(1);
        idx_d   = idx_q;
        snap_d  = snap_q;
        colon_d = colon_q ^ bus.disp_tick_1hz;
        if (cnt_q == c_cnt_last) begin
            cnt_d = '0;
            if (idx_q == c_idx_last) begin
                idx_d  = '0;
                // Capturing all digits at once keeps a frame free of tearing.
                snap_d = w_digits;
            end else begin
                idx_d = idx_q + digit_idx_t'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Output logic for the current slot
    // ------------------------------------------------------------------
    assign w_digit    = snap_q[idx_q];
    assign w_max      = digit_max(idx_q);
    assign w_lit      = (cnt_q >= c_cnt_gap) && !bus.disp_blank;
    assign w_lz_blank = bus.disp_lzb && (idx_q == c_idx_last) && (w_digit == 4'd0);

    bcd_7seg u_bcd_7seg (
        .i_digit (w_digit),
        .i_max   (w_max),
        .o_seg   (w_dec_seg)
    );

    // Leading-zero blanking clears segments but keeps the anode on.
    always_comb begin
        an_d  = 6'h3F;
        seg_d = SEG_BLANK;
        dp_d  = 1'b1;
        if (w_lit) begin
            an_d  = ~(6'b00_0001 << idx_q);
            seg_d = w_lz_blank ? SEG_BLANK : w_dec_seg;
            dp_d  = ~(colon_q && ((idx_q == 3'd2) || (idx_q == 3'd4)));
        end
    end

    assign bus.disp_an  = an_q;
    assign bus.disp_seg = seg_q;
    assign bus.disp_dp  = dp_q;

endmodule

`default_nettype wire

// File: tb/tb_disp_mux.sv
// ============================================================================
// Module      : tb_disp_mux
// Description : Self-checking bench for disp_mux against a cycle-count model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_disp_mux;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    disp_mux_if bus ();

    disp_mux #(
        .SCAN_DIV   (8),
        .GAP_CYCLES (2)
    ) dut (
        .disp_clock (clk),
        .disp_reset (rst),
        .bus        (bus)
    );

    // Reference model: position derived from the number of edges since reset.
    int         m_s;
    int         m_snap [6];
    bit         m_colon;
    logic [5:0] exp_an;
    logic [6:0] exp_seg;
    logic       exp_dp;

    function automatic logic [6:0] ref_seg(input int d, input int lim);
        if (d > lim) return 7'h3F;
        case (d)
            0: return 7'h40;  1: return 7'h79;  2: return 7'h24;  3: return 7'h30;
            4: return 7'h19;  5: return 7'h12;  6: return 7'h02;  7: return 7'h78;
            8: return 7'h00;  default: return 7'h10;
        endcase
    endfunction

    always @(posedge clk) begin
        int cnt, slot, d, lim;
        if (rst) begin
            m_s = 0;
            m_colon = 1'b0;
            for (int i = 0; i < 6; i++) m_snap[i] = 0;
            exp_an = 6'h3F; exp_seg = 7'h7F; exp_dp = 1'b1;
        end else begin
            cnt  = m_s % 8;
            slot = (m_s / 8) % 6;
            if (cnt < 2 || bus.disp_blank) begin
                exp_an = 6'h3F; exp_seg = 7'h7F; exp_dp = 1'b1;
            end else begin
                d   = m_snap[slot];
                lim = (slot == 5) ? 2 : ((slot % 2 == 1) ? 5 : 9);
                exp_an  = 6'h3F ^ (6'd1 << slot);
                exp_seg = (slot == 5 && bus.disp_lzb && d == 0) ? 7'h7F : ref_seg(d, lim);
                exp_dp  = !(m_colon && (slot == 2 || slot == 4));
            end
            if (m_s % 48 == 47) begin
                m_snap[0] = int'(bus.disp_seg_lsd);
                m_snap[1] = int'(bus.disp_seg_msd);
                m_snap[2] = int'(bus.disp_min_lsd);
                m_snap[3] = int'(bus.disp_min_msd);
                m_snap[4] = int'(bus.disp_hor_lsd);
                m_snap[5] = int'(bus.disp_hor_msd);
            end
            if (bus.disp_tick_1hz) m_colon = !m_colon;
            m_s++;
        end
    end

    // Frame position (0..47) whose outputs are currently visible.
    function automatic int shown();
        return (m_s - 1) % 48;
    endfunction

    task automatic set_time(input int h, input int m, input int s);
        bus.disp_hor_msd = 2'(h / 10); bus.disp_hor_lsd = 4'(h % 10);
        bus.disp_min_msd = 3'(m / 10); bus.disp_min_lsd = 4'(m % 10);
        bus.disp_seg_msd = 3'(s / 10); bus.disp_seg_lsd = 4'(s % 10);
    endtask

    task automatic wait_phase(input int p);
        int guard = 0;
        @(negedge clk);
        while (shown() != p && guard < 60) begin
            @(negedge clk);
            guard++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.disp_an !== 6'h3F) begin errors++; $display("FAIL reset_an got %h want 3f", bus.disp_an); end
        checks++;
        if (bus.disp_seg !== 7'h7F) begin errors++; $display("FAIL reset_seg got %h want 7f", bus.disp_seg); end
        checks++;
        if (bus.disp_dp !== 1'b1) begin errors++; $display("FAIL reset_dp got %b want 1", bus.disp_dp); end
        set_time(12, 34, 56);
        rst = 1'b0;
    endtask

    task automatic test_scan();
        int p;
        for (int k = 0; k < 96; k++) begin
            @(negedge clk);
            p = m_s - 1;
            checks++;
            if ({bus.disp_an, bus.disp_seg, bus.disp_dp} !== {exp_an, exp_seg, exp_dp}) begin
                errors++;
                $display("FAIL scan pos=%0d got %h/%h/%b want %h/%h/%b", p, bus.disp_an, bus.disp_seg, bus.disp_dp, exp_an, exp_seg, exp_dp);
            end
            if (p % 8 < 2) begin
                checks++;
                if (bus.disp_an !== 6'h3F) begin errors++; $display("FAIL scan_gap pos=%0d got an=%h want 3f", p, bus.disp_an); end
            end else if (p < 48) begin
                checks++;
                if (bus.disp_seg !== 7'h40) begin errors++; $display("FAIL scan_frame1 pos=%0d got seg=%h want 40", p, bus.disp_seg); end
            end
            if (p == 50) begin
                checks++;
                if ({bus.disp_an, bus.disp_seg} !== {6'h3E, 7'h02}) begin errors++; $display("FAIL scan_slot0 got %h/%h want 3e/02", bus.disp_an, bus.disp_seg); end
            end
            if (p == 90) begin
                checks++;
                if ({bus.disp_an, bus.disp_seg} !== {6'h1F, 7'h79}) begin errors++; $display("FAIL scan_slot5 got %h/%h want 1f/79", bus.disp_an, bus.disp_seg); end
            end
        end
    endtask

    task automatic test_midframe_change();
        wait_phase(3);
        set_time(12, 34, 57);
        for (int k = 1; k <= 47; k++) begin
            @(negedge clk);
            checks++;
            if ({bus.disp_an, bus.disp_seg, bus.disp_dp} !== {exp_an, exp_seg, exp_dp}) begin
                errors++;
                $display("FAIL midchange k=%0d got %h/%h/%b want %h/%h/%b", k, bus.disp_an, bus.disp_seg, bus.disp_dp, exp_an, exp_seg, exp_dp);
            end
            if (k == 2) begin
                checks++;
                if (bus.disp_seg !== 7'h02) begin errors++; $display("FAIL midchange_old got seg=%h want 02", bus.disp_seg); end
            end
            if (k == 47) begin
                checks++;
                if (bus.disp_seg !== 7'h78) begin errors++; $display("FAIL midchange_new got seg=%h want 78", bus.disp_seg); end
            end
        end
    endtask

    task automatic test_lzb();
        set_time(9, 0, 0);
        bus.disp_lzb = 1'b1;
        wait_phase(47);
        wait_phase(42);
        checks++;
        if ({bus.disp_an, bus.disp_seg} !== {6'h1F, 7'h7F}) begin errors++; $display("FAIL lzb_on got %h/%h want 1f/7f", bus.disp_an, bus.disp_seg); end
        bus.disp_lzb = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus.disp_an, bus.disp_seg} !== {6'h1F, 7'h40}) begin errors++; $display("FAIL lzb_off got %h/%h want 1f/40", bus.disp_an, bus.disp_seg); end
    endtask

    task automatic test_invalid();
        set_time(12, 3, 5);
        bus.disp_min_msd = 3'd6;
        bus.disp_seg_lsd = 4'hA;
        wait_phase(47);
        for (int k = 0; k < 48; k++) begin
            @(negedge clk);
            checks++;
            if ({bus.disp_an, bus.disp_seg, bus.disp_dp} !== {exp_an, exp_seg, exp_dp}) begin
                errors++;
                $display("FAIL invalid pos=%0d got %h/%h/%b want %h/%h/%b", k, bus.disp_an, bus.disp_seg, bus.disp_dp, exp_an, exp_seg, exp_dp);
            end
            if (k == 2 || k == 26) begin
                checks++;
                if (bus.disp_seg !== 7'h3F) begin errors++; $display("FAIL invalid_dash pos=%0d got seg=%h want 3f", k, bus.disp_seg); end
            end
        end
    endtask

    task automatic test_tick();
        int   p;
        logic want;
        set_time(12, 34, 56);
        for (int pulse = 1; pulse <= 2; pulse++) begin
            @(negedge clk);
            bus.disp_tick_1hz = 1'b1;
            @(negedge clk);
            bus.disp_tick_1hz = 1'b0;
            for (int k = 0; k < 48; k++) begin
                @(negedge clk);
                p = shown();
                want = !(pulse == 1 && (p % 8) >= 2 && ((p / 8) == 2 || (p / 8) == 4));
                checks++;
                if (bus.disp_dp !== want) begin
                    errors++;
                    $display("FAIL tick%0d_dp pos=%0d got %b want %b", pulse, p, bus.disp_dp, want);
                end
                checks++;
                if ({bus.disp_an, bus.disp_seg, bus.disp_dp} !== {exp_an, exp_seg, exp_dp}) begin
                    errors++;
                    $display("FAIL tick%0d pos=%0d got %h/%h/%b want %h/%h/%b", pulse, p, bus.disp_an, bus.disp_seg, bus.disp_dp, exp_an, exp_seg, exp_dp);
                end
            end
        end
    endtask

    task automatic test_blank_and_reset();
        wait_phase(9);
        bus.disp_blank = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checks++;
            if (bus.disp_an !== 6'h3F) begin errors++; $display("FAIL blank_an k=%0d got %h want 3f", k, bus.disp_an); end
        end
        bus.disp_blank = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.disp_an !== 6'h3D) begin errors++; $display("FAIL blank_resume got an=%h want 3d", bus.disp_an); end
        wait_phase(30);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({bus.disp_an, bus.disp_seg, bus.disp_dp} !== {6'h3F, 7'h7F, 1'b1}) begin
            errors++;
            $display("FAIL midreset got %h/%h/%b want 3f/7f/1", bus.disp_an, bus.disp_seg, bus.disp_dp);
        end
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({bus.disp_an, bus.disp_seg} !== {6'h3E, 7'h40}) begin errors++; $display("FAIL restart_slot0 got %h/%h want 3e/40", bus.disp_an, bus.disp_seg); end
    endtask

    task automatic test_random();
        for (int k = 0; k < 1500; k++) begin
            @(negedge clk);
            checks++;
            if ({bus.disp_an, bus.disp_seg, bus.disp_dp} !== {exp_an, exp_seg, exp_dp}) begin
                errors++;
                $display("FAIL random k=%0d got %h/%h/%b want %h/%h/%b", k, bus.disp_an, bus.disp_seg, bus.disp_dp, exp_an, exp_seg, exp_dp);
            end
            if ($urandom_range(0, 19) == 0) begin
                bus.disp_seg_lsd = 4'($urandom); bus.disp_seg_msd = 3'($urandom);
                bus.disp_min_lsd = 4'($urandom); bus.disp_min_msd = 3'($urandom);
                bus.disp_hor_lsd = 4'($urandom); bus.disp_hor_msd = 2'($urandom);
            end
            bus.disp_tick_1hz = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 39) == 0) bus.disp_blank = !bus.disp_blank;
            if ($urandom_range(0, 63) == 0) bus.disp_lzb = 1'($urandom);
            rst = ($urandom_range(0, 299) == 0);
        end
        rst = 1'b0;
        bus.disp_blank = 1'b0;
        bus.disp_tick_1hz = 1'b0;
    endtask

    initial begin
        bus.disp_tick_1hz = 1'b0;
        bus.disp_lzb      = 1'b0;
        bus.disp_blank    = 1'b0;
        set_time(0, 0, 0);
        test_reset();
        test_scan();
        test_midframe_change();
        test_lzb();
        test_invalid();
        test_tick();
        test_blank_and_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
